mux_sel_sequencer: RTL and testbench
====================================

Name: mux_sel_sequencer

Overview:
Upstream driver for the 8:1 bit-select mux. It accepts an 8-bit word over a valid/ready handshake and holds it on the mux data bus. It then steps the 3-bit select through all eight positions, one per step_en, so the mux output carries the word as a serial bitstream. Supports back-to-back words with no idle gap, and LSB-first or MSB-first order.

Parameters:
MSB_FIRST, 0, 0: select order 0→7 (LSB first); 1: select order 7→0 (MSB first)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
load_data  input  8  word to serialize
load_valid  input  1  load_data is valid
load_ready  output  1  block accepts a word this cycle (combinational)
step_en  input  1  advance select by one position (bit-rate tick)
mux_i  output  8  held word, drives mux data input
mux_sel  output  3  drives mux select input
bit_valid  output  1  mux_i[mux_sel] is a valid serial bit
last  output  1  current select is the final position of the word
done  output  1  one-cycle pulse: final bit of a word consumed, no new word loaded

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, mux_i=8'h00, mux_sel=START, bit_valid=0, done=0. load_ready=0 whenever rst=1.
- START = 3'd0 if MSB_FIRST=0, else 3'd7. END = 3'd7 if MSB_FIRST=0, else 3'd0. Step is +1 or −1 mod 8. The 3-bit wrap is intentional; mux_sel never leaves 0..7.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1, bit_valid=0.
  - On load_valid=1: mux_i<=load_data, mux_sel<=START, go to SHIFT.
  - bit_valid=1 from the next cycle (1-cycle latency accept→first bit).
- SHIFT:
  - bit_valid=1. last = (mux_sel==END).
  - load_ready = last & step_en. No other cycle in SHIFT accepts data.
  - step_en=0: hold mux_i and mux_sel.
  - step_en=1, not last: mux_sel advances one position.
  - step_en=1, last, load_valid=1: capture new word, mux_sel<=START, stay in SHIFT. Seamless: no bit_valid gap, no done pulse.
  - step_en=1, last, load_valid=0: go to IDLE, done=1 for exactly the next cycle.
- mux_i is stable for the whole word; it changes only on an accepted load.
- A word occupies exactly 8 step_en pulses. step_en in IDLE is ignored.
- load_valid ignored when load_ready=0. The upstream source must hold data until accepted.
- Reset mid-word: the word is abandoned, outputs return to reset values on that edge, no done pulse.
- done and load-accept may coincide only via the back-to-back path, which suppresses done.

Test Plan:
1. MSB_FIRST=0, load 8'hA5, step_en held 1 → mux_sel 0,1,…,7 on consecutive cycles. mux_i[mux_sel] = 1,0,1,0,0,1,0,1. last high at sel=7. done pulses 1 cycle after, then IDLE with load_ready=1.
2. MSB_FIRST=1, load 8'h3C, step_en every 4th cycle → mux_sel 7→0, each value held 4 cycles. Serial bits 0,0,1,1,1,1,0,0. Exactly 8 step_en pulses consumed.
3. Back-to-back: load 8'hFF, then present 8'h00 with load_valid during the last step → load_ready=1 only in that cycle. mux_i switches to 8'h00, mux_sel=0, bit_valid stays 1, done never asserts.
4. Backpressure: load_valid=1 with 8'h12 mid-word (sel=3) → load_ready=0, mux_i unchanged. 8'h12 is accepted only at the last step.
5. Reset mid-word: at sel=4 assert rst for 1 cycle → next cycle mux_i=0, mux_sel=START, bit_valid=0, done=0, load_ready=0 during rst, 1 after.
6. step_en pulses in IDLE with load_valid=0 → mux_sel and bit_valid unchanged. No spurious done.

Source files
------------

// File: rtl/mux_sel_sequencer.sv
// rtl/mux_sel_sequencer.sv - serializes an 8-bit word by stepping the 8:1 mux select
// Holds the accepted word on mux_i and walks mux_sel through all eight positions, one per step_en.
module mux_sel_sequencer #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] load_data,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic       step_en,
   output logic [7:0] mux_i,
   output logic [2:0] mux_sel,
   output logic       bit_valid,
   output logic       last,
   output logic       done
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   localparam logic [2:0] SEL_START = MSB_FIRST ? 3'd7 : 3'd0;
   localparam logic [2:0] SEL_END   = MSB_FIRST ? 3'd0 : 3'd7;
   // Adding 7 is a decrement modulo 8, so both orders share one adder.
   localparam logic [2:0] SEL_STEP  = MSB_FIRST ? 3'd7 : 3'd1;

   logic [0:0] state;
   logic       accept;

   assign bit_valid  = (state == SHIFT);
   assign last       = (state == SHIFT) && (mux_sel == SEL_END);
   assign load_ready = !rst && ((state == IDLE) || (last && step_en));
   assign accept     = load_ready && load_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mux_i   <= 8'h00;
         mux_sel <= SEL_START;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            // Covers both the idle load and the seamless back-to-back reload.
            mux_i   <= load_data;
            mux_sel <= SEL_START;
            state   <= SHIFT;
         end else if ((state == SHIFT) && step_en) begin
            if (last) begin
               state <= IDLE;
               done  <= 1'b1;
            end else begin
               mux_sel <= mux_sel + SEL_STEP;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// tb/tb_mux_sel_sequencer.sv - randomized and directed self-checking bench for mux_sel_sequencer
module tb_mux_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] load_data = 8'h00;
   logic       load_valid = 1'b0;
   logic       step_en = 1'b0;

   logic [1:0] lr, bv, ls, dn;
   logic [7:0] mi [2];
   logic [2:0] ms [2];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux_sel_sequencer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(lr[0]), .step_en(step_en), .mux_i(mi[0]), .mux_sel(ms[0]),
      .bit_valid(bv[0]), .last(ls[0]), .done(dn[0]));

   mux_sel_sequencer #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
      .load_ready(lr[1]), .step_en(step_en), .mux_i(mi[1]), .mux_sel(ms[1]),
      .bit_valid(bv[1]), .last(ls[1]), .done(dn[1]));

   // Reference model: a word is "busy" with a count of bits already stepped past.
   bit         m_busy [2] = '{0, 0};
   logic [7:0] m_word [2] = '{8'h00, 8'h00};
   int         m_idx  [2] = '{0, 0};
   bit         m_done [2] = '{0, 0};
   logic [2:0] m_isel [2] = '{3'd0, 3'd7};

   function automatic logic [14:0] exp_vec(int k);
      logic [2:0] sel;
      logic       rdy;
      if (m_busy[k]) sel = (k == 1) ? 3'(7 - m_idx[k]) : 3'(m_idx[k]);
      else           sel = m_isel[k];
      rdy = !rst && (!m_busy[k] || (m_idx[k] == 7 && step_en));
      return {m_word[k], sel, m_busy[k], (m_busy[k] && m_idx[k] == 7), m_done[k], rdy};
   endfunction

   function automatic logic [14:0] dut_vec(int k);
      return {mi[k], ms[k], bv[k], ls[k], dn[k], lr[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_busy[k] = 0; m_word[k] = 8'h00; m_idx[k] = 0; m_done[k] = 0;
            m_isel[k] = (k == 1) ? 3'd7 : 3'd0;
         end else begin
            bit rdy;
            rdy = !m_busy[k] || (m_idx[k] == 7 && step_en);
            m_done[k] = 0;
            if (rdy && load_valid) begin
               m_word[k] = load_data; m_idx[k] = 0; m_busy[k] = 1;
            end else if (m_busy[k] && step_en) begin
               if (m_idx[k] == 7) begin
                  m_busy[k] = 0; m_done[k] = 1;
                  m_isel[k] = (k == 1) ? 3'd0 : 3'd7;
               end else begin
                  m_idx[k]++;
               end
            end
         end
      end
      #1;
   endtask

   task automatic drain(int n);
      load_valid = 0; step_en = 1;
      for (int i = 0; i < n; i++) tick();
      step_en = 0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1; load_valid = 1; step_en = 1; load_data = 8'h77;
      tick(); tick();
      #1;
      checks++;
      if (lr !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", lr); end
      checks++;
      if ({mi[0], mi[1], ms[0], ms[1], bv, dn} !== {8'h00, 8'h00, 3'd0, 3'd7, 2'b00, 2'b00}) begin
         errors++;
         $display("FAIL reset_state mi=%h/%h sel=%0d/%0d bv=%b dn=%b", mi[0], mi[1], ms[0], ms[1], bv, dn);
      end
      rst = 0; load_valid = 0; step_en = 0;
      #1;
      checks++;
      if (lr !== 2'b11) begin errors++; $display("FAIL reset_release_ready got=%b exp=11", lr); end
      tick();
   endtask

   task automatic test_lsb_a5();
      logic [7:0] bits;
      bits = 8'b1010_0101;
      load_data = 8'hA5; load_valid = 1; step_en = 1;
      tick();
      load_valid = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (ms[0] !== 3'(i) || mi[0][ms[0]] !== bits[i] || ls[0] !== (i == 7) || bv[0] !== 1'b1) begin
            errors++;
            $display("FAIL lsb_a5 step=%0d sel=%0d bit=%b last=%b bv=%b exp_bit=%b", i, ms[0], mi[0][ms[0]], ls[0], bv[0], bits[i]);
         end
         checks++;
         if (dut_vec(1) !== exp_vec(1)) begin errors++; $display("FAIL lsb_a5_model1 got=%h exp=%h", dut_vec(1), exp_vec(1)); end
         tick();
      end
      step_en = 0;
      #1;
      checks++;
      if (dn[0] !== 1'b1 || bv[0] !== 1'b0 || lr[0] !== 1'b1) begin
         errors++; $display("FAIL lsb_a5_done dn=%b bv=%b lr=%b exp 1,0,1", dn[0], bv[0], lr[0]);
      end
      tick();
      checks++;
      if (dn !== 2'b00) begin errors++; $display("FAIL lsb_a5_done_width dn=%b exp=00", dn); end
   endtask

   task automatic test_msb_3c();
      logic [7:0] bits;
      int pulses;
      bits = 8'b0011_1100;
      pulses = 0;
      load_data = 8'h3C; load_valid = 1; step_en = 0;
      tick();
      load_valid = 0;
      for (int c = 0; c < 32; c++) begin
         step_en = (c % 4 == 3);
         #1;
         checks++;
         if (ms[1] !== 3'(7 - c / 4) || mi[1][ms[1]] !== bits[7 - c / 4] || dn[1] !== 1'b0) begin
            errors++;
            $display("FAIL msb_3c cycle=%0d sel=%0d bit=%b dn=%b exp_sel=%0d", c, ms[1], mi[1][ms[1]], dn[1], 7 - c / 4);
         end
         if (step_en) pulses++;
         tick();
      end
      step_en = 0;
      #1;
      checks++;
      if (pulses != 8 || dn[1] !== 1'b1 || bv[1] !== 1'b0) begin
         errors++; $display("FAIL msb_3c_end pulses=%0d dn=%b bv=%b exp 8,1,0", pulses, dn[1], bv[1]);
      end
      checks++;
      if (dut_vec(0) !== exp_vec(0)) begin errors++; $display("FAIL msb_3c_model0 got=%h exp=%h", dut_vec(0), exp_vec(0)); end
      tick();
   endtask

   task automatic test_back_to_back();
      load_data = 8'hFF; load_valid = 1; step_en = 1;
      tick();
      load_data = 8'h00;
      for (int i = 0; i < 8; i++) begin
         #1;
         checks++;
         if (lr[0] !== (i == 7) || mi[0] !== 8'hFF || dn[0] !== 1'b0) begin
            errors++; $display("FAIL b2b_ready step=%0d lr=%b mi=%h dn=%b", i, lr[0], mi[0], dn[0]);
         end
         tick();
      end
      load_valid = 0;
      #1;
      checks++;
      if (mi[0] !== 8'h00 || ms[0] !== 3'd0 || bv[0] !== 1'b1 || dn[0] !== 1'b0) begin
         errors++; $display("FAIL b2b_switch mi=%h sel=%0d bv=%b dn=%b exp 00,0,1,0", mi[0], ms[0], bv[0], dn[0]);
      end
      drain(8);
   endtask

   task automatic test_backpressure();
      load_data = 8'h5A; load_valid = 1; step_en = 1;
      tick();
      load_valid = 0;
      tick(); tick(); tick();
      load_data = 8'h12; load_valid = 1; step_en = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ms[0] !== 3'd3 || lr[0] !== 1'b0 || mi[0] !== 8'h5A) begin
            errors++; $display("FAIL bp_hold sel=%0d lr=%b mi=%h exp 3,0,5a", ms[0], lr[0], mi[0]);
         end
         tick();
      end
      step_en = 1;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (lr[0] !== (i == 4) || mi[0] !== 8'h5A) begin
            errors++; $display("FAIL bp_accept step=%0d lr=%b mi=%h", i, lr[0], mi[0]);
         end
         tick();
      end
      load_valid = 0;
      #1;
      checks++;
      if (mi[0] !== 8'h12 || ms[0] !== 3'd0 || dn[0] !== 1'b0) begin
         errors++; $display("FAIL bp_loaded mi=%h sel=%0d dn=%b exp 12,0,0", mi[0], ms[0], dn[0]);
      end
      drain(8);
   endtask

   task automatic test_reset_mid();
      load_data = 8'hC3; load_valid = 1; step_en = 1;
      tick();
      load_valid = 0;
      for (int i = 0; i < 4; i++) tick();
      step_en = 0; rst = 1;
      #1;
      checks++;
      if (ms[0] !== 3'd4 || lr !== 2'b00) begin
         errors++; $display("FAIL rstmid_pre sel=%0d lr=%b exp 4,00", ms[0], lr);
      end
      tick();
      checks++;
      if (mi[0] !== 8'h00 || ms[0] !== 3'd0 || ms[1] !== 3'd7 || bv !== 2'b00 || dn !== 2'b00) begin
         errors++; $display("FAIL rstmid_post mi=%h sel=%0d/%0d bv=%b dn=%b", mi[0], ms[0], ms[1], bv, dn);
      end
      rst = 0;
      #1;
      checks++;
      if (lr !== 2'b11) begin errors++; $display("FAIL rstmid_ready lr=%b exp=11", lr); end
      tick();
      checks++;
      if (dn !== 2'b00 || bv !== 2'b00) begin errors++; $display("FAIL rstmid_nodone dn=%b bv=%b", dn, bv); end
   endtask

   task automatic test_idle_steps();
      logic [2:0] s0, s1;
      s0 = ms[0]; s1 = ms[1];
      load_valid = 0;
      for (int i = 0; i < 6; i++) begin
         step_en = i[0];
         tick();
         checks++;
         if (ms[0] !== s0 || ms[1] !== s1 || bv !== 2'b00 || dn !== 2'b00) begin
            errors++; $display("FAIL idle_step i=%0d sel=%0d/%0d bv=%b dn=%b", i, ms[0], ms[1], bv, dn);
         end
      end
      step_en = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         step_en = ($urandom_range(0, 2) != 0);
         if (!load_valid || lr[0]) begin
            load_valid = ($urandom_range(0, 3) != 0);
            load_data = 8'($urandom);
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== exp_vec(k)) begin
               errors++; $display("FAIL random k=%0d cycle=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
            end
         end
         tick();
      end
      rst = 0; load_valid = 0; step_en = 0;
   endtask

   initial begin
      test_reset();
      test_lsb_a5();
      test_msb_3c();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_idle_steps();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
